cc_level_sequencer: RTL and testbench

//  Sequences the level datapath: drives CurrentLvl/LvlProgress into CC_LEVEL_DATAHANDLER, one road row per scroll tick.

---
 rtl/cc_level_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_cc_level_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cc_level_sequencer.sv
// Level sequencer: steps banner/play segments with blank gap rows, one row per scroll tick,
// and handles crash freeze, lives, pause, win and game-over.
module cc_level_sequencer #(
  parameter int unsigned LEN_BANNER  = 8,
  parameter int unsigned LEN_PLAY1   = 10,
  parameter int unsigned LEN_PLAY2   = 15,
  parameter int unsigned LEN_PLAY3   = 20,
  parameter int unsigned GAP_ROWS    = 4,
  parameter int unsigned CRASH_TICKS = 6,
  parameter int unsigned LIVES       = 3
) (
  input  logic       CC_LEVEL_SEQUENCER_CLOCK_50,
  input  logic       CC_LEVEL_SEQUENCER_RESET_InLow,
  input  logic       CC_LEVEL_SEQUENCER_Start_In,
  input  logic       CC_LEVEL_SEQUENCER_Tick_In,
  input  logic       CC_LEVEL_SEQUENCER_Pause_In,
  input  logic       CC_LEVEL_SEQUENCER_Crash_In,
  output logic [2:0] CC_LEVEL_SEQUENCER_CurrentLvl_Out,
  output logic [4:0] CC_LEVEL_SEQUENCER_LvlProgress_Out,
  output logic       CC_LEVEL_SEQUENCER_RowLoad_Out,
  output logic       CC_LEVEL_SEQUENCER_LvlDone_Out,
  output logic [1:0] CC_LEVEL_SEQUENCER_Lives_Out,
  output logic       CC_LEVEL_SEQUENCER_Win_Out,
  output logic       CC_LEVEL_SEQUENCER_GameOver_Out
);

  localparam int unsigned LVL_W  = 3;
  localparam int unsigned PROG_W = 5;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned LIV_W  = 2;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_GAP   = 3'd2;
  localparam logic [2:0] ST_CRASH = 3'd3;
  localparam logic [2:0] ST_WIN   = 3'd4;
  localparam logic [2:0] ST_OVER  = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [LVL_W-1:0]  lvl_q, lvl_d;
  logic [PROG_W-1:0] prog_q, prog_d;
  logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]  crash_cnt_q, crash_cnt_d;
  logic [LIV_W-1:0]  lives_q, lives_d;
  logic              row_load_q, row_load_d;
  logic              lvl_done_q, lvl_done_d;
  logic              win_q, win_d;
  logic              game_over_q, game_over_d;

  logic              tick_c;
  logic              crash_c;
  logic [PROG_W-1:0] len_c;

  assign tick_c  = CC_LEVEL_SEQUENCER_Tick_In  & ~CC_LEVEL_SEQUENCER_Pause_In;
  assign crash_c = CC_LEVEL_SEQUENCER_Crash_In & ~CC_LEVEL_SEQUENCER_Pause_In;

  // Segment length for the current level; odd levels are banners.
  always_comb begin
    len_c = PROG_W'(LEN_BANNER);
    case (lvl_q)
      3'd2:    len_c = PROG_W'(LEN_PLAY1);
      3'd4:    len_c = PROG_W'(LEN_PLAY2);
      3'd6:    len_c = PROG_W'(LEN_PLAY3);
      default: len_c = PROG_W'(LEN_BANNER);
    endcase
  end

  always_comb begin
    state_d     = state_q;
    lvl_d       = lvl_q;
    prog_d      = prog_q;
    gap_cnt_d   = gap_cnt_q;
    crash_cnt_d = crash_cnt_q;
    lives_d     = lives_q;
    win_d       = win_q;
    game_over_d = game_over_q;
    row_load_d  = 1'b0;
    lvl_done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_WIN, ST_OVER: begin
        if (CC_LEVEL_SEQUENCER_Start_In) begin
          state_d     = ST_RUN;
          lvl_d       = LVL_W'(1);
          prog_d      = '0;
          gap_cnt_d   = '0;
          crash_cnt_d = '0;
          lives_d     = LIV_W'(LIVES);
          win_d       = 1'b0;
          game_over_d = 1'b0;
        end
      end
      ST_RUN: begin
        // Crashes only count on play levels and pre-empt a same-cycle tick.
        if (crash_c && !lvl_q[0]) begin
          prog_d = '0;
          if (lives_q == LIV_W'(1)) begin
            state_d     = ST_OVER;
            lives_d     = '0;
            game_over_d = 1'b1;
          end else begin
            state_d     = ST_CRASH;
            lives_d     = lives_q - LIV_W'(1);
            crash_cnt_d = '0;
          end
        end else if (tick_c) begin
          row_load_d = 1'b1;
          if (prog_q < len_c) begin
            prog_d = prog_q + PROG_W'(1);
          end else begin
            state_d    = ST_GAP;
            prog_d     = '0;
            gap_cnt_d  = CNT_W'(1);
            lvl_done_d = 1'b1;
          end
        end
      end
      ST_GAP: begin
        if (tick_c) begin
          if (gap_cnt_q < CNT_W'(GAP_ROWS)) begin
            gap_cnt_d  = gap_cnt_q + CNT_W'(1);
            row_load_d = 1'b1;
          end else if (lvl_q < LVL_W'(6)) begin
            state_d    = ST_RUN;
            lvl_d      = lvl_q + LVL_W'(1);
            prog_d     = PROG_W'(1);
            gap_cnt_d  = '0;
            row_load_d = 1'b1;
          end else begin
            state_d   = ST_WIN;
            lvl_d     = LVL_W'(7);
            prog_d    = '0;
            gap_cnt_d = '0;
            win_d     = 1'b1;
          end
        end
      end
      ST_CRASH: begin
        if (tick_c) begin
          if (crash_cnt_q == CNT_W'(CRASH_TICKS - 1)) begin
            state_d     = ST_RUN;
            prog_d      = PROG_W'(1);
            crash_cnt_d = '0;
            row_load_d  = 1'b1;
          end else begin
            crash_cnt_d = crash_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CC_LEVEL_SEQUENCER_CLOCK_50 or negedge CC_LEVEL_SEQUENCER_RESET_InLow) begin
    if (!CC_LEVEL_SEQUENCER_RESET_InLow) begin
      state_q     <= ST_IDLE;
      lvl_q       <= '0;
      prog_q      <= '0;
      gap_cnt_q   <= '0;
      crash_cnt_q <= '0;
      lives_q     <= LIV_W'(LIVES);
      row_load_q  <= 1'b0;
      lvl_done_q  <= 1'b0;
      win_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lvl_q       <= lvl_d;
      prog_q      <= prog_d;
      gap_cnt_q   <= gap_cnt_d;
      crash_cnt_q <= crash_cnt_d;
      lives_q     <= lives_d;
      row_load_q  <= row_load_d;
      lvl_done_q  <= lvl_done_d;
      win_q       <= win_d;
      game_over_q <= game_over_d;
    end
  end

  assign CC_LEVEL_SEQUENCER_CurrentLvl_Out  = lvl_q;
  assign CC_LEVEL_SEQUENCER_LvlProgress_Out = prog_q;
  assign CC_LEVEL_SEQUENCER_RowLoad_Out     = row_load_q;
  assign CC_LEVEL_SEQUENCER_LvlDone_Out     = lvl_done_q;
  assign CC_LEVEL_SEQUENCER_Lives_Out       = lives_q;
  assign CC_LEVEL_SEQUENCER_Win_Out         = win_q;
  assign CC_LEVEL_SEQUENCER_GameOver_Out    = game_over_q;

endmodule

// File: tb/tb_cc_level_sequencer.sv
// Self-checking bench for cc_level_sequencer: vector table for the first segment, a row-stream
// scoreboard for a full game, and directed crash/pause/reset sequences.
module tb_cc_level_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, tick = 1'b0, pause = 1'b0, crash = 1'b0;
  logic [2:0] lvl_o;
  logic [4:0] prog_o;
  logic       rl_o, ld_o, win_o, go_o;
  logic [1:0] lives_o;

  always #5 clk = ~clk;

  cc_level_sequencer dut (
    .CC_LEVEL_SEQUENCER_CLOCK_50       (clk),
    .CC_LEVEL_SEQUENCER_RESET_InLow    (rst_n),
    .CC_LEVEL_SEQUENCER_Start_In       (start),
    .CC_LEVEL_SEQUENCER_Tick_In        (tick),
    .CC_LEVEL_SEQUENCER_Pause_In       (pause),
    .CC_LEVEL_SEQUENCER_Crash_In       (crash),
    .CC_LEVEL_SEQUENCER_CurrentLvl_Out (lvl_o),
    .CC_LEVEL_SEQUENCER_LvlProgress_Out(prog_o),
    .CC_LEVEL_SEQUENCER_RowLoad_Out    (rl_o),
    .CC_LEVEL_SEQUENCER_LvlDone_Out    (ld_o),
    .CC_LEVEL_SEQUENCER_Lives_Out      (lives_o),
    .CC_LEVEL_SEQUENCER_Win_Out        (win_o),
    .CC_LEVEL_SEQUENCER_GameOver_Out   (go_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: condition not met (t=%0t)", nm, $time);
  endtask

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic cyc(input logic s, input logic t, input logic c, input logic p);
    start = s; tick = t; crash = c; pause = p;
    @(posedge clk);
    #1;
    start = 1'b0; tick = 1'b0; crash = 1'b0;
  endtask

  task automatic tick_pair();
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; tick = 1'b0; crash = 1'b0; pause = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic tick_until(input int l, input int p);
    bit found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (int'(lvl_o) == l && int'(prog_o) == p) begin
        found = 1'b1;
        break;
      end
      tick_pair();
    end
    if (!found) fail_now($sformatf("reach_lvl%0d_prog%0d", l, p));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_lvl"}, int'(lvl_o), 0);
    chk({tag, "_prog"}, int'(prog_o), 0);
    chk({tag, "_rowload"}, int'(rl_o), 0);
    chk({tag, "_lvldone"}, int'(ld_o), 0);
    chk({tag, "_lives"}, int'(lives_o), 3);
    chk({tag, "_win"}, int'(win_o), 0);
    chk({tag, "_gameover"}, int'(go_o), 0);
  endtask

  typedef struct {
    logic s, t, c;
    int   lvl, prog, rl, ld;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic t, input logic c,
                              input int lvl, input int prog, input int rl, input int ld);
    vec_t v;
    v.s = s; v.t = t; v.c = c; v.lvl = lvl; v.prog = prog; v.rl = rl; v.ld = ld;
    return v;
  endfunction

  // Row-stream scoreboard: expected (lvl, prog, lvldone) per RowLoad pulse.
  typedef struct {
    int lvl, prog, ld;
  } row_t;
  row_t row_q[$];
  bit   sb_en  = 1'b0;
  int   rl_cnt = 0;
  int   ld_cnt = 0;
  logic rl_prev = 1'b0;

  always @(negedge clk) begin
    if (rl_o) chk("rowload_single_cycle", int'(rl_prev), 0);
    rl_prev = rl_o;
    if (sb_en && ld_o) ld_cnt++;
    if (sb_en && rl_o) begin
      rl_cnt++;
      if (row_q.size() == 0) begin
        fail_now("sb_unexpected_row");
      end else begin
        row_t r;
        r = row_q.pop_front();
        chk("sb_lvl", int'(lvl_o), r.lvl);
        chk("sb_prog", int'(prog_o), r.prog);
        chk("sb_lvldone", int'(ld_o), r.ld);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  vec_t tbl[14];
  int   lens[6];

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1, 0, 0, 0);
    tbl[1]  = mk(1'b0, 1'b1, 1'b0, 1, 1, 1, 0);
    tbl[2]  = mk(1'b0, 1'b1, 1'b0, 1, 2, 1, 0);
    tbl[3]  = mk(1'b0, 1'b1, 1'b0, 1, 3, 1, 0);
    tbl[4]  = mk(1'b0, 1'b1, 1'b0, 1, 4, 1, 0);
    tbl[5]  = mk(1'b0, 1'b1, 1'b0, 1, 5, 1, 0);
    tbl[6]  = mk(1'b0, 1'b1, 1'b0, 1, 6, 1, 0);
    tbl[7]  = mk(1'b0, 1'b1, 1'b0, 1, 7, 1, 0);
    tbl[8]  = mk(1'b0, 1'b1, 1'b0, 1, 8, 1, 0);
    tbl[9]  = mk(1'b0, 1'b1, 1'b0, 1, 0, 1, 1);
    tbl[10] = mk(1'b0, 1'b1, 1'b0, 1, 0, 1, 0);
    tbl[11] = mk(1'b0, 1'b1, 1'b0, 1, 0, 1, 0);
    tbl[12] = mk(1'b0, 1'b1, 1'b1, 1, 0, 1, 0);
    tbl[13] = mk(1'b0, 1'b1, 1'b0, 2, 1, 1, 0);
    lens = '{8, 10, 8, 15, 8, 20};

    // Reset values and ticks ignored in IDLE
    do_reset();
    chk_reset_vals("reset");
    tick_pair();
    chk("idle_tick_lvl", int'(lvl_o), 0);
    chk("idle_tick_rowload", int'(rl_o), 0);

    // First banner and gap from the vector table
    foreach (tbl[i]) begin
      cyc(tbl[i].s, tbl[i].t, tbl[i].c, 1'b0);
      chk($sformatf("vec%0d_lvl", i), int'(lvl_o), tbl[i].lvl);
      chk($sformatf("vec%0d_prog", i), int'(prog_o), tbl[i].prog);
      chk($sformatf("vec%0d_rowload", i), int'(rl_o), tbl[i].rl);
      chk($sformatf("vec%0d_lvldone", i), int'(ld_o), tbl[i].ld);
      chk($sformatf("vec%0d_lives", i), int'(lives_o), 3);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      chk($sformatf("vec%0d_idle_rowload", i), int'(rl_o), 0);
      chk($sformatf("vec%0d_idle_prog", i), int'(prog_o), tbl[i].prog);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("start_in_run_ignored_lvl", int'(lvl_o), 2);
    chk("start_in_run_ignored_prog", int'(prog_o), 1);

    // Full game through the row-stream scoreboard
    do_reset();
    row_q.delete();
    for (int s = 1; s <= 6; s++) begin
      for (int p = 1; p <= lens[s-1]; p++) row_q.push_back('{s, p, 0});
      row_q.push_back('{s, 0, 1});
      for (int g = 2; g <= 4; g++) row_q.push_back('{s, 0, 0});
    end
    rl_cnt = 0;
    ld_cnt = 0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    sb_en = 1'b1;
    for (int i = 0; i < 400 && !win_o; i++) tick_pair();
    sb_en = 1'b0;
    chk("full_win", int'(win_o), 1);
    chk("full_lvl", int'(lvl_o), 7);
    chk("full_prog", int'(prog_o), 0);
    chk("full_rowloads", rl_cnt, 93);
    chk("full_lvldones", ld_cnt, 6);
    chk("full_rows_left", row_q.size(), 0);
    tick_pair();
    chk("win_hold_rowload", int'(rl_o), 0);
    chk("win_hold_lvl", int'(lvl_o), 7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("win_restart_lvl", int'(lvl_o), 1);
    chk("win_restart_prog", int'(prog_o), 0);
    chk("win_restart_win", int'(win_o), 0);

    // Crash with same-cycle tick in level 4, then freeze and resume
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tick_until(4, 9);
    cyc(1'b0, 1'b1, 1'b1, 1'b0);
    chk("crash4_lives", int'(lives_o), 2);
    chk("crash4_prog", int'(prog_o), 0);
    chk("crash4_rowload", int'(rl_o), 0);
    chk("crash4_lvl", int'(lvl_o), 4);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("crash4_start_ignored", int'(lvl_o), 4);
    for (int k = 1; k <= 5; k++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("frozen%0d_rowload", k), int'(rl_o), 0);
      chk($sformatf("frozen%0d_prog", k), int'(prog_o), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("resume4_lvl", int'(lvl_o), 4);
    chk("resume4_prog", int'(prog_o), 1);
    chk("resume4_rowload", int'(rl_o), 1);
    chk("resume4_lvldone", int'(ld_o), 0);

    // Three crashes in level 2 end the game
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tick_until(2, 3);
    for (int n = 1; n <= 2; n++) begin
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      chk($sformatf("crash%0d_lives", n), int'(lives_o), 3 - n);
      for (int k = 0; k < 5; k++) tick_pair();
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      chk($sformatf("crash%0d_resume_prog", n), int'(prog_o), 1);
      chk($sformatf("crash%0d_resume_rowload", n), int'(rl_o), 1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("over_lives", int'(lives_o), 0);
    chk("over_flag", int'(go_o), 1);
    chk("over_prog", int'(prog_o), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b0, 1'b1, 1'b1, 1'b0);
      chk($sformatf("over_tick%0d_rowload", k), int'(rl_o), 0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
    end
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("restart_lvl", int'(lvl_o), 1);
    chk("restart_prog", int'(prog_o), 0);
    chk("restart_lives", int'(lives_o), 3);
    chk("restart_gameover", int'(go_o), 0);
    chk("restart_rowload", int'(rl_o), 0);

    // Pause freezes ticks and crashes in level 2
    tick_until(2, 2);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b0, (i % 4) == 1, i == 10, 1'b1);
      chk($sformatf("pause%0d_lvl", i), int'(lvl_o), 2);
      chk($sformatf("pause%0d_prog", i), int'(prog_o), 2);
      chk($sformatf("pause%0d_rowload", i), int'(rl_o), 0);
      chk($sformatf("pause%0d_lives", i), int'(lives_o), 3);
    end
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("unpause_prog", int'(prog_o), 3);
    chk("unpause_rowload", int'(rl_o), 1);

    // Crashes ignored in banner and gap; async reset mid-gap
    do_reset();
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    tick_until(1, 3);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("banner_crash_lives", int'(lives_o), 3);
    chk("banner_crash_prog", int'(prog_o), 3);
    tick_pair();
    chk("banner_after_crash_prog", int'(prog_o), 4);
    tick_until(1, 8);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_entry_lvldone", int'(ld_o), 1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("gap_crash_lives", int'(lives_o), 3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_blank_rowload", int'(rl_o), 1);
    chk("gap_blank_prog", int'(prog_o), 0);
    chk("gap_blank_lvl", int'(lvl_o), 1);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    @(posedge clk);
    #1;
    chk("async_reset_hold_rowload", int'(rl_o), 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
